// File: rtl/hazard_if.sv
// Decode/execute hazard-control bundle: ID/EX hazard sources in, pipeline steering out.
// master = pipeline side that drives hazard sources, slave = hazard_ctrl.
interface hazard_if #(
    parameter int CNT_W = 8
);
    logic [1:0]       id_ra;
    logic [1:0]       id_rb;
    logic             id_uses_ra;
    logic             id_uses_rb;
    logic [1:0]       ex_dest;
    logic             ex_reg_write;
    logic             ex_mem_to_reg;
    logic             ex_io_read;
    logic             ex_is_call;
    logic             ex_is_ret;
    logic             ex_is_loop;
    logic             ex_loop_taken;
    logic             ex_branch_taken;
    logic             stall_clr;

    logic             pc_write_en;
    logic             if_id_write_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [1:0]       pc_sel;
    logic             busy;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_ra, id_rb, id_uses_ra, id_uses_rb, ex_dest, ex_reg_write,
               ex_mem_to_reg, ex_io_read, ex_is_call, ex_is_ret, ex_is_loop,
               ex_loop_taken, ex_branch_taken, stall_clr,
        input  pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, pc_sel,
               busy, stall_count
    );

    modport slave (
        input  id_ra, id_rb, id_uses_ra, id_uses_rb, ex_dest, ex_reg_write,
               ex_mem_to_reg, ex_io_read, ex_is_call, ex_is_ret, ex_is_loop,
               ex_loop_taken, ex_branch_taken, stall_clr,
        output pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, pc_sel,
               busy, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Decode/execute sequencing controller: load-use / IO-read stalls, EX redirects,
// multi-cycle RET wait and a saturating count of PC-stalled cycles.
module hazard_ctrl #(
    parameter int RET_LAT = 2,
    parameter int CNT_W   = 8
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  hz
);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_RET_WAIT = 1'b1;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_EX  = 2'b01;
    localparam logic [1:0] PC_RET = 2'b10;

    localparam logic [3:0]       RET_INIT = 4'(RET_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [3:0]       ret_cnt_q;
    logic [3:0]       ret_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic       hazard_ld_s;
    logic       redirect_s;
    logic       pc_we_s;
    logic       ifid_we_s;
    logic       ifid_flush_s;
    logic       idex_flush_s;
    logic [1:0] pc_sel_s;

    // Hazard detection and Mealy output / next-state decode.
    always_comb begin
        hazard_ld_s = (hz.ex_mem_to_reg | hz.ex_io_read) & hz.ex_reg_write &
                      ((hz.id_uses_ra & (hz.id_ra == hz.ex_dest)) |
                       (hz.id_uses_rb & (hz.id_rb == hz.ex_dest)));
        redirect_s  = hz.ex_is_call | (hz.ex_is_loop & hz.ex_loop_taken) |
                      hz.ex_branch_taken;

        pc_we_s      = 1'b1;
        ifid_we_s    = 1'b1;
        ifid_flush_s = 1'b0;
        idex_flush_s = 1'b0;
        pc_sel_s     = PC_SEQ;
        state_d      = state_q;
        ret_cnt_d    = ret_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (redirect_s) begin
                    // A redirect also overrides an (illegal) simultaneous RET.
                    pc_sel_s     = PC_EX;
                    ifid_flush_s = 1'b1;
                    idex_flush_s = 1'b1;
                end else if (hz.ex_is_ret) begin
                    pc_we_s      = 1'b0;
                    ifid_flush_s = 1'b1;
                    idex_flush_s = 1'b1;
                    state_d      = ST_RET_WAIT;
                    ret_cnt_d    = RET_INIT;
                end else if (hazard_ld_s) begin
                    pc_we_s      = 1'b0;
                    ifid_we_s    = 1'b0;
                    idex_flush_s = 1'b1;
                end else begin
                    pc_we_s = 1'b1;
                end
            end
            ST_RET_WAIT: begin
                ifid_flush_s = 1'b1;
                idex_flush_s = 1'b1;
                if (ret_cnt_q != 4'd0) begin
                    pc_we_s   = 1'b0;
                    ret_cnt_d = ret_cnt_q - 4'd1;
                end else begin
                    pc_sel_s = PC_RET;
                    state_d  = ST_RUN;
                end
            end
            default: begin
                state_d   = ST_RUN;
                ret_cnt_d = 4'd0;
            end
        endcase
    end

    // Stall counter next value: clear wins, otherwise saturating increment on stall.
    always_comb begin
        if (hz.stall_clr) begin
            stall_cnt_d = {CNT_W{1'b0}};
        end else if (!pc_we_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, RET countdown and stall counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            ret_cnt_q   <= 4'd0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            ret_cnt_q   <= ret_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset forces every steering output low immediately, independent of the clock.
    assign hz.pc_write_en    = pc_we_s & ~rst;
    assign hz.if_id_write_en = ifid_we_s & ~rst;
    assign hz.if_id_flush    = ifid_flush_s & ~rst;
    assign hz.id_ex_flush    = idex_flush_s & ~rst;
    assign hz.pc_sel         = rst ? PC_SEQ : pc_sel_s;
    assign hz.busy           = (state_q != ST_RUN) & ~rst;
    assign hz.stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;

    localparam int RET_LAT = 2;
    localparam int CNT_W   = 8;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   m_wait;   // remaining RET_WAIT cycles, 0 = running
    int   m_cnt;    // expected stall count
    logic [CNT_W-1:0] snap;

    hazard_if #(.CNT_W(CNT_W)) hif();

    hazard_ctrl #(.RET_LAT(RET_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic [1:0] ra, input logic [1:0] rb, input logic ua,
                          input logic ub, input logic [1:0] dest, input logic rw,
                          input logic mtr, input logic io, input logic call,
                          input logic ret, input logic loop, input logic ltk,
                          input logic br, input logic clr);
        hif.id_ra = ra;          hif.id_rb = rb;
        hif.id_uses_ra = ua;     hif.id_uses_rb = ub;
        hif.ex_dest = dest;      hif.ex_reg_write = rw;
        hif.ex_mem_to_reg = mtr; hif.ex_io_read = io;
        hif.ex_is_call = call;   hif.ex_is_ret = ret;
        hif.ex_is_loop = loop;   hif.ex_loop_taken = ltk;
        hif.ex_branch_taken = br; hif.stall_clr = clr;
    endtask

    task automatic idle_in();
        set_in(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0);
    endtask

    // Called just after a negedge with inputs applied; returns at the next negedge.
    task automatic check_cycle(input string tag);
        logic [6:0] exp_v;
        logic [6:0] obs_v;
        logic [CNT_W-1:0] exp_c;
        logic ld;
        logic redir;
        #1;
        ld = (hif.ex_mem_to_reg || hif.ex_io_read) && hif.ex_reg_write &&
             ((hif.id_uses_ra && hif.id_ra == hif.ex_dest) ||
              (hif.id_uses_rb && hif.id_rb == hif.ex_dest));
        redir = hif.ex_is_call || (hif.ex_is_loop && hif.ex_loop_taken) ||
                hif.ex_branch_taken;
        if (rst) begin
            m_wait = 0;
            m_cnt  = 0;
            exp_v  = 7'b0000000;
        end else if (m_wait > 1) exp_v = 7'b0111_00_1;
        else if (m_wait == 1)    exp_v = 7'b1111_10_1;
        else if (redir)          exp_v = 7'b1111_01_0;
        else if (hif.ex_is_ret)  exp_v = 7'b0111_00_0;
        else if (ld)             exp_v = 7'b0001_00_0;
        else                     exp_v = 7'b1100_00_0;
        exp_c = CNT_W'(m_cnt);
        obs_v = {hif.pc_write_en, hif.if_id_write_en, hif.if_id_flush, hif.id_ex_flush,
                 hif.pc_sel, hif.busy};
        n_cmp++;
        assert (obs_v === exp_v) else begin
            n_bad++;
            $error("FAIL %s outputs{pcwe,ifidwe,ifidfl,idexfl,pcsel,busy}: observed %b expected %b",
                   tag, obs_v, exp_v);
        end
        n_cmp++;
        assert (hif.stall_count === exp_c) else begin
            n_bad++;
            $error("FAIL %s stall_count: observed %0d expected %0d", tag, hif.stall_count, exp_c);
        end
        @(posedge clk);
        if (rst) begin
            m_wait = 0;
            m_cnt  = 0;
        end else begin
            if (hif.stall_clr) m_cnt = 0;
            else if (exp_v[6] == 1'b0 && m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
            if (m_wait > 0) m_wait = m_wait - 1;
            else if (!redir && hif.ex_is_ret) m_wait = RET_LAT;
        end
        @(negedge clk);
    endtask

    task automatic expect_cnt(input string tag, input logic [CNT_W-1:0] want);
        #1;
        n_cmp++;
        assert (hif.stall_count === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, hif.stall_count, want);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        m_wait = 0;
        m_cnt  = 0;
        rst    = 1'b1;
        idle_in();
        @(negedge clk);
        check_cycle("reset");
        rst = 1'b0;
        check_cycle("post_reset_idle");

        // Load-use on RA: one bubble, counted.
        set_in(2'd2, 2'd0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_cycle("load_use_ra");
        expect_cnt("load_use_count", 8'd1);
        // Same but RA unused, then a non-matching destination.
        set_in(2'd2, 2'd0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_cycle("ra_unused");
        set_in(2'd2, 2'd0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_cycle("dest_mismatch");
        // IO read hazard through RB.
        set_in(2'd0, 2'd1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_cycle("io_read_rb");
        // CALL redirect.
        set_in(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_cycle("call");
        // Branch with hazard_ld conditions: redirect wins.
        set_in(2'd2, 2'd0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_cycle("branch_over_load");
        // LOOP not taken with no hazard is a normal cycle; taken is a redirect.
        set_in(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_cycle("loop_not_taken");
        set_in(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_cycle("loop_taken");

        // RET: RET_LAT stalls then return address, EX/ID ignored while waiting.
        snap = hif.stall_count;
        set_in(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_cycle("ret_c0");
        set_in(2'd1, 2'd1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_cycle("ret_c1");
        check_cycle("ret_c2");
        idle_in();
        check_cycle("ret_c3_run");
        expect_cnt("ret_stall_plus2", snap + 8'd2);

        // Reset in the middle of RET_WAIT.
        set_in(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_cycle("ret_before_rst");
        idle_in();
        rst = 1'b1;
        check_cycle("rst_mid_wait");
        rst = 1'b0;
        check_cycle("run_after_rst");

        // Saturation then clear.
        set_in(2'd3, 2'd0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) check_cycle("load_use_run");
        expect_cnt("saturated", 8'd255);
        hif.stall_clr = 1'b1;
        check_cycle("clear_wins");
        expect_cnt("cleared", 8'd0);
        idle_in();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            set_in(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                   ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 19) == 0));
            rst = ($urandom_range(0, 59) == 0);
            check_cycle("random");
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
